mc_ram_loader: RTL and testbench

Boot-time initiator for the microcode control store. Accepts a byte stream from the front-panel/boot link, assembles WIDTH-bit microinstructions, writes each one into the control store RAM with a properly framed active-low write strobe, then reads it back and compares before moving on. Sits between the boot interface and the control store chip-select/output-enable/write pins; the sequencer is held off while `busy` is high.

---
 rtl/mc_defs.sv | 23 ++
 rtl/mc_word_assembler.sv | 38 +++
 rtl/mc_ram_loader.sv | 135 +++++++++++++
 tb/tb_mc_ram_loader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_defs.sv
// Shared definitions for the microcode control store loader.
package mc_defs;

    localparam int ADDR_W            = 8;
    localparam int WIDTH_DEF         = 64;
    localparam int BYTES_PER_WORD    = WIDTH_DEF / 8;
    localparam int ACCESS_CYCLES_DEF = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_SETUP,
        S_WPULSE,
        S_HOLD,
        S_READ,
        S_CHECK
    } state_t;

    function automatic int bytes_per_word(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/mc_word_assembler.sv
// Little-endian byte-to-word assembler; word_ready marks the final byte.
module mc_word_assembler
    import mc_defs::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             _reset,
    input  logic             clr,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic [WIDTH-1:0] word,
    output logic             word_ready
);

    localparam int BPW = bytes_per_word(WIDTH);
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sr;

    // Newest byte enters at the top so the first byte ends up in [7:0].
    assign word       = (sr >> 8) | (WIDTH'(byte_data) << (WIDTH - 8));
    assign word_ready = byte_valid && (cnt == CW'(BPW - 1));

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            cnt <= '0;
            sr  <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (byte_valid) begin
            sr  <= word;
            cnt <= word_ready ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mc_ram_loader.sv
// Boot loader for the microcode control store: write, read back, verify.
module mc_ram_loader
    import mc_defs::*;
#(
    parameter int WIDTH         = WIDTH_DEF,
    parameter int DEPTH         = 256,
    parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              _reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [8:0]        num_words,
    input  logic [7:0]        load_data,
    input  logic              load_valid,
    output logic              load_ready,
    output logic              _cs,
    output logic              _oe,
    output logic              _w,
    output logic [ADDR_W-1:0] addr,
    output logic [WIDTH-1:0]  wdata,
    input  logic [WIDTH-1:0]  rdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] err_addr
);

    state_t           state;
    logic [3:0]       cyc;
    logic [8:0]       words_left;
    logic [WIDTH-1:0] rd_q;
    logic [WIDTH-1:0] word;
    logic             word_ready;
    logic             take;

    assign take = start && (state == S_IDLE);
    assign busy = (state != S_IDLE);

    mc_word_assembler #(.WIDTH(WIDTH)) u_asm (
        .clk        (clk),
        ._reset     (_reset),
        .clr        (take),
        .byte_valid (load_valid && load_ready),
        .byte_data  (load_data),
        .word       (word),
        .word_ready (word_ready)
    );

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state      <= S_IDLE;
            cyc        <= '0;
            words_left <= '0;
            rd_q       <= '0;
            load_ready <= 1'b0;
            _cs        <= 1'b1;
            _oe        <= 1'b1;
            _w         <= 1'b1;
            addr       <= '0;
            wdata      <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            err_addr   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: if (take) begin
                    error    <= 1'b0;
                    err_addr <= '0;
                    addr     <= base_addr;
                    words_left <= (num_words > 9'(DEPTH)) ? 9'(DEPTH) : num_words;
                    if (num_words == '0) begin
                        done <= 1'b1;
                    end else begin
                        load_ready <= 1'b1;
                        state      <= S_COLLECT;
                    end
                end
                S_COLLECT: if (word_ready) begin
                    wdata      <= word;
                    load_ready <= 1'b0;
                    _cs        <= 1'b0;
                    state      <= S_SETUP;
                end
                S_SETUP: begin
                    _w    <= 1'b0;
                    cyc   <= '0;
                    state <= S_WPULSE;
                end
                S_WPULSE: begin
                    if (cyc == 4'(ACCESS_CYCLES - 1)) begin
                        _w    <= 1'b1;
                        state <= S_HOLD;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                S_HOLD: begin
                    _oe   <= 1'b0;
                    cyc   <= '0;
                    state <= S_READ;
                end
                S_READ: begin
                    if (cyc == 4'(ACCESS_CYCLES)) begin
                        rd_q  <= rdata;
                        _oe   <= 1'b1;
                        state <= S_CHECK;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                S_CHECK: begin
                    _cs <= 1'b1;
                    if (rd_q != wdata) begin
                        error    <= 1'b1;
                        err_addr <= addr;
                        done     <= 1'b1;
                        state    <= S_IDLE;
                    end else if (words_left == 9'd1) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        addr       <= addr + 1'b1;
                        words_left <= words_left - 1'b1;
                        load_ready <= 1'b1;
                        state      <= S_COLLECT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ram_loader.sv
// Randomized bench for mc_ram_loader with a behavioural control store model.
module tb_mc_ram_loader;

    logic        clk = 1'b0;
    logic        _reset;
    logic        start;
    logic [7:0]  base_addr;
    logic [8:0]  num_words;
    logic [7:0]  load_data;
    logic        load_valid;
    logic        load_ready;
    logic        _cs, _oe, _w;
    logic [7:0]  addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        busy, done, error;
    logic [7:0]  err_addr;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int viol   = 0;
    int cs_low = 0;

    logic [63:0] mem [256];
    logic        stuck_en = 1'b0;
    logic [7:0]  stuck_addr = 8'h05;

    logic [7:0]  wr_addr_q [$];
    logic [63:0] wr_data_q [$];
    int          wr_len_q  [$];
    int          wlen = 0;
    logic        pw = 1'b1;
    logic [7:0]  pa = '0;
    logic [63:0] pd = '0;

    mc_ram_loader dut (
        .clk        (clk),
        ._reset     (_reset),
        .start      (start),
        .base_addr  (base_addr),
        .num_words  (num_words),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_ready (load_ready),
        ._cs        (_cs),
        ._oe        (_oe),
        ._w         (_w),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_addr   (err_addr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Control store model with an optional stuck-at-0 bit 0 at one address.
    always @(posedge clk) if (!_cs && !_w) mem[addr] <= wdata;
    assign rdata = (!_cs && !_oe) ?
        (mem[addr] & ~((stuck_en && addr == stuck_addr) ? 64'd1 : 64'd0)) : '0;

    always @(negedge clk) begin
        if (!_w && pw) begin
            wr_addr_q.push_back(addr);
            wr_data_q.push_back(wdata);
            wlen = 1;
        end else if (!_w) begin
            wlen++;
            if (addr != pa || wdata != pd) viol++;
        end
        if (_w && !pw) wr_len_q.push_back(wlen);
        if (!_oe && !_w) viol++;
        if (!_cs) cs_low++;
        pw = _w;
        pa = addr;
        pd = wdata;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cs"}, _cs, 1);
        chk({tag, "_oe"}, _oe, 1);
        chk({tag, "_w"}, _w, 1);
        chk({tag, "_ready"}, load_ready, 0);
        chk({tag, "_addr"}, addr, 0);
        chk({tag, "_wdata"}, wdata, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, error, 0);
        chk({tag, "_erra"}, err_addr, 0);
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_len_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stall, output int acc);
        int t = 0;
        if (stall) begin
            load_valid = 1'b0;
            @(negedge clk);
        end
        load_valid = 1'b1;
        load_data  = b;
        while (!load_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!load_ready) chk("ready_timeout", load_ready, 1);
        acc = cyc;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic load_word(input logic [63:0] d, input bit stall, output int acc);
        int a;
        for (int k = 0; k < 8; k++) begin
            send_byte(d[8*k +: 8], stall, a);
            if (k == 0) acc = a;
        end
    endtask

    task automatic run_load(input logic [7:0] base, input int n, input bit stall,
                            input bit mid_start, input int bad_idx,
                            input bit fixed, output int acc0, output int done_at);
        int eff, nsend, t, acc;
        bit bad;
        logic [63:0] d;
        logic [63:0] exp_d [$];
        logic [7:0]  exp_a [$];
        eff   = (n > 256) ? 256 : n;
        bad   = (bad_idx >= 0 && bad_idx < eff);
        nsend = bad ? bad_idx + 1 : eff;
        acc0  = 0;
        clear_log();
        start = 1'b1;
        base_addr = base;
        num_words = 9'(n);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < nsend; i++) begin
            d = fixed ? 64'h0807060504030201 : {$urandom(), $urandom()};
            if (i == bad_idx) d[0] = 1'b1;
            exp_d.push_back(d);
            exp_a.push_back(base + 8'(i));
            load_word(d, stall, acc);
            if (i == 0) acc0 = acc;
            if (mid_start && i == 0) begin
                start = 1'b1;
                base_addr = 8'hAA;
                num_words = 9'd1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        t = 0;
        while (!done && t < 200) begin
            @(negedge clk);
            t++;
        end
        done_at = cyc;
        chk("done_seen", done, 1);
        chk("error", error, bad);
        chk("err_addr", err_addr, bad ? exp_a[bad_idx] : 8'h00);
        chk("n_writes", wr_addr_q.size(), nsend);
        for (int i = 0; i < nsend && i < wr_addr_q.size(); i++) begin
            chk("wr_addr", wr_addr_q[i], exp_a[i]);
            chk("wr_data", wr_data_q[i], exp_d[i]);
            if (i < wr_len_q.size()) chk("w_width", wr_len_q[i], 2);
        end
        @(negedge clk);
        chk("busy_after", busy, 0);
        chk("cs_after", _cs, 1);
    endtask

    initial begin
        int acc0, done_at, t, c0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        _reset = 1'b0;
        start = 1'b0;
        base_addr = '0;
        num_words = '0;
        load_data = '0;
        load_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        _reset = 1'b1;
        @(negedge clk);

        run_load(8'h10, 1, 0, 0, -1, 1, acc0, done_at);
        chk("done_latency", done_at - acc0, 16);
        chk("mem_10", mem[8'h10], 64'h0807060504030201);

        run_load(8'hFE, 3, 0, 0, -1, 0, acc0, done_at);

        stuck_en = 1'b1;
        run_load(8'h00, 8, 0, 0, 5, 0, acc0, done_at);
        stuck_en = 1'b0;

        run_load(8'h40, 3, 1, 1, -1, 0, acc0, done_at);

        c0 = cs_low;
        start = 1'b1;
        base_addr = 8'h33;
        num_words = 9'd0;
        @(negedge clk);
        start = 1'b0;
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("zero_no_cs", cs_low - c0, 0);

        for (int r = 0; r < 4; r++)
            run_load(8'($urandom()), $urandom_range(1, 6), 1'($urandom()), 0, -1, 0,
                     acc0, done_at);

        run_load(8'($urandom()), 300, 0, 0, -1, 0, acc0, done_at);

        start = 1'b1;
        base_addr = 8'h20;
        num_words = 9'd2;
        @(negedge clk);
        start = 1'b0;
        load_word({$urandom(), $urandom()}, 0, acc0);
        t = 0;
        while (_w && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("w_low_seen", _w, 0);
        #1 _reset = 1'b0;
        #1 chk("rst_w_async", _w, 1);
        @(negedge clk);
        chk_reset_vals("mid");
        _reset = 1'b1;
        c0 = cs_low;
        repeat (6) @(negedge clk);
        chk("post_rst_no_cs", cs_low - c0, 0);
        chk("post_rst_idle", busy, 0);
        clear_log();

        chk("protocol", viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
